srio_type9_arb: RTL and testbench
=================================

// Module: srio_type9_arb
// PURPOSE
//  Packet-granular round-robin arbiter sharing one SRIO type-9 TX stream among NUM_REQ packer outputs.
//  Each packer presents a complete packet on its own AXIS slave port, with TDATA and TUSER (srcdest).
//  Grant is held from first beat to TLAST; data then passes straight through to the SRIO core TX port.
//  Provides an enable mask, grant/busy status, a packet counter and error flags for the AXI-lite register block.
// PARAMETERS
//  NUM_REQ      4     number of requesting streams (2..8)
//  MAX_BEATS    34    beats per packet above which ERR_OVERSIZE sets
//  STALL_CYC    1024  cycles of granted-source TVALID low mid-packet before ERR_STALL sets
// PORTS
//  AXIS_ACLK      in   1            single clock for the whole block
//  AXIS_RESET     in   1            synchronous, active-high reset
//  S_AXIS_TVALID  in   NUM_REQ      per-source valid
//  S_AXIS_TREADY  out  NUM_REQ      per-source ready
//  S_AXIS_TDATA   in   64*NUM_REQ   source i occupies bits [64*i+63:64*i]
//  S_AXIS_TUSER   in   32*NUM_REQ   srcdest for source i, bits [32*i+31:32*i]
//  S_AXIS_TLAST   in   NUM_REQ      per-source end of packet
//  M_AXIS_TVALID  out  1            to SRIO TX
//  M_AXIS_TREADY  in   1
//  M_AXIS_TDATA   out  64
//  M_AXIS_TUSER   out  32
//  M_AXIS_TLAST   out  1
//  EN_MASK        in   NUM_REQ      1 = source may win arbitration
//  ERR_CLR        in   1            1-cycle pulse, clears sticky error flags
//  GRANT          out  NUM_REQ      one-hot current grant, 0 when idle
//  BUSY           out  1            1 while in XFER
//  PKT_CNT        out  16           completed packets, wraps 0xFFFF->0
//  ERR_OVERSIZE   out  1            sticky
//  ERR_STALL      out  1            sticky
// BEHAVIOUR
//  FSM has two states, IDLE and XFER. Reset puts it in IDLE.
//  Reset values:
//   - GRANT=0, BUSY=0, PKT_CNT=0, ERR_*=0.
//   - All S_AXIS_TREADY=0, M_AXIS_TVALID=0.
//   - last_grant=NUM_REQ-1, so source 0 has first priority.
//  IDLE:
//   - All TREADY=0 and M_AXIS_TVALID=0.
//   - req = S_AXIS_TVALID & EN_MASK. If req!=0, pick the first set bit searching from last_grant+1 upward, mod NUM_REQ.
//   - Register that pick into GRANT and go to XFER at the next edge.
//  XFER, granted source g:
//   - Combinational pass-through: M_AXIS_TVALID/TDATA/TUSER/TLAST come from source g, and S_AXIS_TREADY[g]=M_AXIS_TREADY.
//   - All other TREADY=0. When not in XFER, M_AXIS_TDATA/TUSER/TLAST are 0.
//  Packet end and latency:
//   - A beat with M_AXIS_TVALID&M_AXIS_TREADY&M_AXIS_TLAST completes the packet.
//   - On that beat: last_grant<=g, PKT_CNT<=PKT_CNT+1, GRANT<=0, and the FSM returns to IDLE.
//   - Every packet costs one IDLE bubble cycle. Latency from TVALID seen in IDLE to first output beat is 1 cycle.
//  Mid-packet changes:
//   - Clearing EN_MASK[g] never aborts a packet; it only affects the next arbitration.
//   - A non-granted source's TVALID and TLAST are ignored.
//  Beat counter:
//   - Counts accepted beats of the current packet and resets on TLAST.
//   - If count reaches MAX_BEATS and the beat is not TLAST, ERR_OVERSIZE<=1. Data is still passed unmodified.
//   - The counter saturates at MAX_BEATS.
//  Stall counter:
//   - In XFER, counts consecutive cycles with S_AXIS_TVALID[g]=0, and clears on any valid.
//   - At STALL_CYC it sets ERR_STALL<=1 and saturates. The grant is kept; there is no timeout abort.
//   - Backpressure (M_AXIS_TREADY=0) does not count.
//  Error flags: ERR_CLR clears both flags. If ERR_CLR coincides with a set condition, the set wins.
//  Single-beat packet (TVALID&TLAST on the first beat) is legal: one cycle in XFER, then IDLE.
//  Reset mid-packet:
//   - At the reset edge: GRANT=0, counters cleared, FSM in IDLE.
//   - The partially sent packet is truncated; the downstream frame checker handles it.
//  PKT_CNT increment and ERR_CLR are independent; the counter is cleared only by reset.
// TESTING
//  T1 round-robin:
//   - Stimulus: all 4 sources hold 3-beat packets, EN_MASK=4'hF, M_AXIS_TREADY=1.
//   - Required: output order 0,1,2,3,0, a 1-cycle gap between packets, PKT_CNT=5, TUSER matches the source each time.
//  T2 mask:
//   - Stimulus: EN_MASK=4'b0101, all valid.
//   - Required: only sources 0 and 2 are served, alternating. S_AXIS_TREADY[1] and S_AXIS_TREADY[3] stay 0.
//  T3 backpressure:
//   - Stimulus: toggle M_AXIS_TREADY 1,0,1,0 during an 8-beat packet from source 1.
//   - Required: all 8 beats appear in order, grant held throughout, no loss, no duplication.
//  T4 errors:
//   - Oversize: a 40-beat packet with MAX_BEATS=34 gives ERR_OVERSIZE=1 after beat 34, and all 40 beats pass.
//   - Stall: source TVALID low for 1024 cycles mid-packet gives ERR_STALL=1.
//   - Clear: an ERR_CLR pulse clears both flags.
//  T5 reset:
//   - Stimulus: assert AXIS_RESET=1 at beat 2 of a 5-beat packet.
//   - Required: next cycle GRANT=0, TREADY=0, PKT_CNT=0. After release, source 0 wins first.
//  T6 corner cases:
//   - Single-beat packets back-to-back from one source: each takes 2 cycles.
//   - PKT_CNT preset near 0xFFFF by running packets wraps to 0.

Source files
------------

// File: rtl/srio_type9_arb.sv
// srio_type9_arb
//   Packet-granular round-robin arbiter that shares one SRIO type-9 TX AXIS
//   stream among NUM_REQ packer outputs. A grant is held from the first beat
//   to TLAST, and the granted source passes straight through to the TX port.
// Ports
//   AXIS_ACLK, AXIS_RESET         clock, synchronous active-high reset
//   S_AXIS_*                      NUM_REQ slave streams (64b data, 32b srcdest)
//   M_AXIS_*                      single master stream to the SRIO core
//   EN_MASK                       per-source arbitration enable
//   ERR_CLR                       pulse that clears the sticky error flags
//   GRANT, BUSY, PKT_CNT          status: one-hot grant, transfer active,
//                                 completed packet count (wraps)
//   ERR_OVERSIZE, ERR_STALL       sticky error flags
module srio_type9_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 34,
    parameter int STALL_CYC = 1024
) (
    input  logic                   AXIS_ACLK,
    input  logic                   AXIS_RESET,
    input  logic [NUM_REQ-1:0]     S_AXIS_TVALID,
    output logic [NUM_REQ-1:0]     S_AXIS_TREADY,
    input  logic [64*NUM_REQ-1:0]  S_AXIS_TDATA,
    input  logic [32*NUM_REQ-1:0]  S_AXIS_TUSER,
    input  logic [NUM_REQ-1:0]     S_AXIS_TLAST,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic [63:0]            M_AXIS_TDATA,
    output logic [31:0]            M_AXIS_TUSER,
    output logic                   M_AXIS_TLAST,
    input  logic [NUM_REQ-1:0]     EN_MASK,
    input  logic                   ERR_CLR,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic                   BUSY,
    output logic [15:0]            PKT_CNT,
    output logic                   ERR_OVERSIZE,
    output logic                   ERR_STALL
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int SW = $clog2(STALL_CYC + 1);
    localparam int unsigned NR = NUM_REQ;
    localparam logic [BW-1:0] BEAT_MAX   = BW'(MAX_BEATS);
    localparam logic [BW-1:0] BEAT_WARN  = BW'(MAX_BEATS - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYC);
    localparam logic [SW-1:0] STALL_WARN = SW'(STALL_CYC - 1);
    localparam logic [IW-1:0] LAST_INIT  = IW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] req;
    logic [BW-1:0]      beat_cnt;
    logic [SW-1:0]      stall_cnt;
    logic [15:0]        pkt_cnt;
    logic               fire;
    logic               ovs_set;
    logic               stall_set;

    assign PKT_CNT = pkt_cnt;

    // Round-robin pick: scan offsets NUM_REQ down to 1 from last_grant so the
    // lowest offset (the source right after the last winner) is written last.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        req      = S_AXIS_TVALID & EN_MASK;
        pick_idx = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(last_grant) + NR - k) % NR;
            if (req[idx[IW-1:0]]) pick_idx = idx[IW-1:0];
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    // Combinational pass-through from the granted source.
    always_comb begin
        S_AXIS_TREADY = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TUSER  = '0;
        M_AXIS_TLAST  = 1'b0;
        if (state == XFER) begin
            M_AXIS_TVALID       = S_AXIS_TVALID[gidx];
            M_AXIS_TDATA        = S_AXIS_TDATA[64*gidx +: 64];
            M_AXIS_TUSER        = S_AXIS_TUSER[32*gidx +: 32];
            M_AXIS_TLAST        = S_AXIS_TLAST[gidx];
            S_AXIS_TREADY[gidx] = M_AXIS_TREADY;
        end
    end

    assign fire      = M_AXIS_TVALID & M_AXIS_TREADY;
    // This beat brings the accepted count to MAX_BEATS without ending the packet.
    assign ovs_set   = fire & ~M_AXIS_TLAST & (beat_cnt >= BEAT_WARN);
    // This cycle is the STALL_CYC-th consecutive one with the source idle.
    assign stall_set = (state == XFER) & ~M_AXIS_TVALID & (stall_cnt >= STALL_WARN);

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_RESET) begin
            state        <= IDLE;
            gidx         <= '0;
            last_grant   <= LAST_INIT;
            GRANT        <= '0;
            BUSY         <= 1'b0;
            pkt_cnt      <= '0;
            beat_cnt     <= '0;
            stall_cnt    <= '0;
            ERR_OVERSIZE <= 1'b0;
            ERR_STALL    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt  <= '0;
                    stall_cnt <= '0;
                    if (|req) begin
                        gidx  <= pick_idx;
                        GRANT <= pick_oh;
                        BUSY  <= 1'b1;
                        state <= XFER;
                    end
                end
                XFER: begin
                    // Backpressure with the source valid is not a stall.
                    if (M_AXIS_TVALID) stall_cnt <= '0;
                    else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
                    if (fire) begin
                        if (M_AXIS_TLAST) begin
                            beat_cnt   <= '0;
                            last_grant <= gidx;
                            pkt_cnt    <= pkt_cnt + 16'd1;
                            GRANT      <= '0;
                            BUSY       <= 1'b0;
                            state      <= IDLE;
                        end else if (beat_cnt != BEAT_MAX) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (ovs_set)      ERR_OVERSIZE <= 1'b1;
            else if (ERR_CLR) ERR_OVERSIZE <= 1'b0;
            if (stall_set)    ERR_STALL <= 1'b1;
            else if (ERR_CLR) ERR_STALL <= 1'b0;
        end
    end

endmodule

// File: tb/tb_srio_type9_arb.sv
// tb_srio_type9_arb
//   Directed bench for srio_type9_arb. Each source is a small packet generator
//   whose beats carry {source, packet number, beat number}; the output stream
//   is logged and compared against hand-derived orderings and counts.
module tb_srio_type9_arb;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    s_tvalid, s_tready, s_tlast;
    logic [64*N-1:0] s_tdata;
    logic [32*N-1:0] s_tuser;
    logic            m_tvalid, m_tready, m_tlast;
    logic [63:0]     m_tdata;
    logic [31:0]     m_tuser;
    logic [N-1:0]    en_mask, grant;
    logic            err_clr, busy, err_ovs, err_stall;
    logic [15:0]     pkt_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int           src_req[N]  = '{default: 0};
    int           src_len[N]  = '{default: 1};
    logic [N-1:0] src_hold    = '0;
    int           src_done[N] = '{default: 0};
    int           src_beat[N] = '{default: 0};

    int          log_src[$];
    int          log_beat[$];
    int          log_cyc[$];
    logic        log_last[$];
    logic [31:0] log_user[$];

    int ord1[5]  = '{0, 1, 2, 3, 0};
    int ord2a[4] = '{2, 0, 2, 0};
    int ord2b[4] = '{1, 3, 1, 3};

    srio_type9_arb #(.NUM_REQ(N), .MAX_BEATS(34), .STALL_CYC(1024)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_RESET    (rst),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TREADY (s_tready),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TUSER  (s_tuser),
        .S_AXIS_TLAST  (s_tlast),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TREADY (m_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TUSER  (m_tuser),
        .M_AXIS_TLAST  (m_tlast),
        .EN_MASK       (en_mask),
        .ERR_CLR       (err_clr),
        .GRANT         (grant),
        .BUSY          (busy),
        .PKT_CNT       (pkt_cnt),
        .ERR_OVERSIZE  (err_ovs),
        .ERR_STALL     (err_stall)
    );

    // Source generators: advance on handshake, restart the current packet on reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                src_beat[i] <= 0;
            end else if (s_tvalid[i] && s_tready[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] <= 0;
                    src_done[i] <= src_done[i] + 1;
                end else begin
                    src_beat[i] <= src_beat[i] + 1;
                end
            end
        end
    end

    always_comb begin
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tuser  = '0;
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = (src_req[i] > src_done[i]) && !src_hold[i];
            s_tlast[i]           = (src_beat[i] == src_len[i] - 1);
            s_tdata[64*i +: 64]  = {8'(i), 8'(src_done[i]), 48'(src_beat[i])};
            s_tuser[32*i +: 32]  = 32'hA000_0000 | 32'(i);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor; the handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("tready_outside_grant", 64'(s_tready & ~grant), 64'd0);
            if (m_tvalid && m_tready) begin
                log_src.push_back(int'(m_tdata[63:56]));
                log_beat.push_back(int'(m_tdata[31:0]));
                log_last.push_back(m_tlast);
                log_user.push_back(m_tuser);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_log(input int target, input int budget, input string tag);
        int b;
        b = 0;
        while (log_src.size() < target && b < budget) begin
            @(negedge clk);
            #1;
            b++;
        end
        chk(tag, 64'(log_src.size() >= target), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=no_finish required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        en_mask  = 4'hF;
        m_tready = 1'b1;
        err_clr  = 1'b0;

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_ovs", err_ovs, 0);
        chk("rst_err_stall", err_stall, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1 round-robin: source 0 has two 3-beat packets, others one
        for (int i = 0; i < N; i++) src_len[i] = 3;
        src_req[0] = 2; src_req[1] = 1; src_req[2] = 1; src_req[3] = 1;
        wait_log(15, 200, "t1_timeout");
        tick(2);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("t1_src_%0d_%0d", k, j), log_src[3*k+j], ord1[k]);
                chk($sformatf("t1_beat_%0d_%0d", k, j), log_beat[3*k+j], j);
                chk($sformatf("t1_last_%0d_%0d", k, j), log_last[3*k+j], (j == 2));
                chk($sformatf("t1_user_%0d_%0d", k, j), log_user[3*k+j], 32'hA000_0000 | 32'(ord1[k]));
            end
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("t1_gap_%0d", k), log_cyc[3*k+3] - log_cyc[3*k+2], 2);
        chk("t1_pkt_cnt", pkt_cnt, 5);
        chk("t1_idle_grant", grant, 0);
        chk("t1_idle_busy", busy, 0);

        // T2 mask: only 0 and 2 enabled, all sources hold two 2-beat packets
        en_mask = 4'b0101;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 2;
            src_req[i] = src_req[i] + 2;
        end
        wait_log(23, 200, "t2_timeout");
        tick(3);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_src_%0d", k), log_src[15+2*k], ord2a[k]);
            chk($sformatf("t2_beat0_%0d", k), log_beat[15+2*k], 0);
        end
        chk("t2_no_extra", log_src.size(), 23);
        chk("t2_masked_grant", grant, 0);
        chk("t2_masked_tready", s_tready, 0);
        chk("t2_pkt_cnt", pkt_cnt, 9);
        en_mask = 4'hF;
        wait_log(31, 200, "t2b_timeout");
        tick(2);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2b_src_%0d", k), log_src[23+2*k], ord2b[k]);
        chk("t2b_pkt_cnt", pkt_cnt, 13);

        // T3 backpressure: 8-beat packet from source 1 with toggling TREADY
        src_len[1] = 8;
        src_req[1] = src_req[1] + 1;
        for (int c = 0; c < 60 && log_src.size() < 39; c++) begin
            m_tready = (c % 2 == 0);
            @(negedge clk);
            if (busy) chk("t3_grant_held", grant, 4'b0010);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        chk("t3_timeout", 64'(log_src.size() >= 39), 1);
        tick(2);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t3_src_%0d", j), log_src[31+j], 1);
            chk($sformatf("t3_beat_%0d", j), log_beat[31+j], j);
            chk($sformatf("t3_last_%0d", j), log_last[31+j], (j == 7));
        end
        chk("t3_no_dup", log_src.size(), 39);
        chk("t3_pkt_cnt", pkt_cnt, 14);

        // T4 oversize: 40-beat packet from source 2
        src_len[2] = 40;
        src_req[2] = src_req[2] + 1;
        wait_log(73, 200, "t4_ovs_timeout");
        chk("t4_ovs_before_beat34", err_ovs, 0);
        @(negedge clk);
        chk("t4_ovs_after_beat34", err_ovs, 1);
        wait_log(79, 200, "t4_ovs_timeout2");
        tick(2);
        for (int j = 0; j < 40; j++) begin
            chk($sformatf("t4_beat_%0d", j), log_beat[39+j], j);
            chk($sformatf("t4_src_%0d", j), log_src[39+j], 2);
        end
        chk("t4_last", log_last[78], 1);
        chk("t4_ovs_sticky", err_ovs, 1);
        chk("t4_stall_clear", err_stall, 0);
        chk("t4_pkt_cnt", pkt_cnt, 15);

        // T4 stall: source 3 drops TVALID after beat 1 for 1024+ cycles
        src_len[3] = 4;
        src_req[3] = src_req[3] + 1;
        wait_log(81, 200, "t4_stall_timeout");
        @(posedge clk);
        #1;
        src_hold[3] = 1'b1;
        tick(1023);
        chk("t4_stall_before", err_stall, 0);
        chk("t4_stall_grant", grant, 4'b1000);
        chk("t4_stall_busy", busy, 1);
        tick(1);
        chk("t4_stall_after", err_stall, 1);
        tick(5);
        chk("t4_stall_sticky", err_stall, 1);
        src_hold[3] = 1'b0;
        wait_log(83, 200, "t4_stall_timeout2");
        tick(2);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t4s_src_%0d", j), log_src[79+j], 3);
            chk($sformatf("t4s_beat_%0d", j), log_beat[79+j], j);
        end
        chk("t4s_pkt_cnt", pkt_cnt, 16);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t4_clr_ovs", err_ovs, 0);
        chk("t4_clr_stall", err_stall, 0);
        chk("t4_clr_pkt_cnt", pkt_cnt, 16);

        // T5 reset mid-packet: source 0 goes first so last_grant is 0
        src_len[0] = 1;
        src_req[0] = src_req[0] + 1;
        wait_log(84, 200, "t5_pre_timeout");
        tick(2);
        chk("t5_pre_src", log_src[83], 0);
        src_len[1] = 5;
        src_req[1] = src_req[1] + 1;
        wait_log(87, 200, "t5_beat2_timeout");
        rst        = 1'b1;
        src_len[0] = 2;
        src_req[0] = src_req[0] + 1;
        @(negedge clk);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_tready", s_tready, 0);
        chk("t5_rst_pkt_cnt", pkt_cnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_m_tvalid", m_tvalid, 0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = log_src.size();
        wait_log(base + 7, 200, "t5_post_timeout");
        tick(2);
        chk("t5_first_src", log_src[base], 0);
        chk("t5_first_last", log_last[base+1], 1);
        chk("t5_second_src", log_src[base+2], 1);
        chk("t5_second_beat0", log_beat[base+2], 0);
        chk("t5_second_end", log_beat[base+6], 4);
        chk("t5_pkt_cnt", pkt_cnt, 2);

        // T6 single-beat back-to-back from source 2, with the counter near wrap
        force dut.pkt_cnt = 16'hFFFD;
        #1;
        release dut.pkt_cnt;
        src_len[2] = 1;
        src_req[2] = src_req[2] + 3;
        base = log_src.size();
        wait_log(base + 3, 100, "t6_timeout");
        tick(2);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t6_src_%0d", j), log_src[base+j], 2);
            chk($sformatf("t6_last_%0d", j), log_last[base+j], 1);
        end
        chk("t6_spacing_0", log_cyc[base+1] - log_cyc[base], 2);
        chk("t6_spacing_1", log_cyc[base+2] - log_cyc[base+1], 2);
        chk("t6_pkt_cnt_wrap", pkt_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
